hash_job_host: RTL

//  Host-side initiator for bitcoin_hash: the opposite end of its start/done + shared-memory protocol.

---
 rtl/hash_pkg.sv | 23 ++
 rtl/hash_result_scan.sv | 41 ++++
 rtl/hash_job_host.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/hash_pkg.sv
// Shared types and default sizing for the bitcoin_hash host-side job initiator.
package hash_pkg;

    localparam int NUM_NONCES_DEF = 16;
    localparam int HDR_WORDS_DEF  = 20;
    localparam int READ_LAT_DEF   = 1;
    localparam logic [15:0] MSG_ADDR_DEF = 16'h0000;
    localparam logic [15:0] OUT_ADDR_DEF = 16'h0100;

    typedef enum logic [2:0] {
        LOAD,
        KICK,
        WAIT_LO,
        WAIT_HI,
        FETCH,
        REPORT
    } host_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hash_result_scan.sv
// Running minimum of H0 results plus first-index-below-target tracker.
module hash_result_scan
    import hash_pkg::*;
#(
    parameter int NUM_NONCES = NUM_NONCES_DEF,
    localparam int IDX_W = idx_width(NUM_NONCES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    input  logic [31:0]      in_h0,
    input  logic [31:0]      target,
    output logic             found,
    output logic [IDX_W-1:0] nonce,
    output logic [31:0]      min_h0
);

    always_ff @(posedge clk) begin
        if (reset) begin
            found  <= 1'b0;
            nonce  <= '0;
            min_h0 <= '0;
        end else if (clear) begin
            found  <= 1'b0;
            nonce  <= '0;
            min_h0 <= 32'hFFFF_FFFF;
        end else if (in_valid) begin
            // Strict compare keeps the earliest index on ties.
            if (in_h0 < min_h0) begin
                min_h0 <= in_h0;
            end
            if (!found && (in_h0 < target)) begin
                found <= 1'b1;
                nonce <= in_idx;
            end
        end
    end

endmodule

// File: rtl/hash_job_host.sv
// Host-side initiator: writes a block header to shared memory, starts the hasher,
// waits for completion, reads back the H0 results and reports the best nonce.
//
//  state   | meaning
//  LOAD    | accepting header words, each written straight to memory
//  KICK    | one-cycle hash_start, memory handed to the hasher
//  WAIT_LO | waiting for hash_done to drop (hasher has accepted the job)
//  WAIT_HI | waiting for hash_done to rise (hasher finished)
//  FETCH   | issuing result reads and scanning the returned data
//  REPORT  | holding the result until res_ready
module hash_job_host
    import hash_pkg::*;
#(
    parameter int          NUM_NONCES = NUM_NONCES_DEF,
    parameter int          HDR_WORDS  = HDR_WORDS_DEF,
    parameter logic [15:0] MSG_ADDR   = MSG_ADDR_DEF,
    parameter logic [15:0] OUT_ADDR   = OUT_ADDR_DEF,
    parameter int          READ_LAT   = READ_LAT_DEF,
    localparam int         IDX_W      = idx_width(NUM_NONCES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hdr_valid,
    output logic             hdr_ready,
    input  logic [31:0]      hdr_data,
    input  logic [31:0]      target,
    output logic             mem_we,
    output logic [15:0]      mem_addr,
    output logic [31:0]      mem_write_data,
    input  logic [31:0]      mem_read_data,
    output logic             mem_grant_hasher,
    output logic [15:0]      message_addr,
    output logic [15:0]      output_addr,
    output logic             hash_start,
    input  logic             hash_done,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_found,
    output logic [IDX_W-1:0] res_nonce,
    output logic [31:0]      res_min_h0
);

    localparam int FETCH_LEN = NUM_NONCES + READ_LAT;
    localparam int FCNT_W    = $clog2(FETCH_LEN + 1);

    host_state_t state, state_next;

    logic [4:0]        word_cnt;
    logic [FCNT_W-1:0] fetch_cnt;
    logic [31:0]       target_q;
    logic              hdr_fire;
    logic              last_word;
    logic              fetch_last;
    logic              scan_clear;
    logic              scan_valid;
    logic [IDX_W-1:0]  scan_idx;

    assign message_addr = MSG_ADDR;
    assign output_addr  = OUT_ADDR;

    assign hdr_fire   = (state == LOAD) && hdr_valid && !reset;
    assign last_word  = (word_cnt == 5'(HDR_WORDS - 1));
    assign fetch_last = (fetch_cnt == FCNT_W'(FETCH_LEN - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_cnt  <= '0;
            fetch_cnt <= '0;
            target_q  <= '0;
        end else begin
            if (hdr_fire) begin
                if (word_cnt == 5'd0) begin
                    target_q <= target;
                end
                word_cnt <= last_word ? 5'd0 : word_cnt + 5'd1;
            end else if ((state == REPORT) && res_ready) begin
                word_cnt <= '0;
            end

            if (state == FETCH) begin
                fetch_cnt <= fetch_last ? '0 : fetch_cnt + 1'b1;
            end else begin
                fetch_cnt <= '0;
            end
        end
    end

    always_comb begin
        state_next       = state;
        hdr_ready        = 1'b0;
        mem_we           = 1'b0;
        mem_addr         = '0;
        mem_write_data   = '0;
        mem_grant_hasher = 1'b0;
        hash_start       = 1'b0;
        res_valid        = 1'b0;
        scan_clear       = 1'b0;

        case (state)
            LOAD: begin
                hdr_ready = 1'b1;
                if (hdr_fire) begin
                    mem_we         = 1'b1;
                    mem_addr       = MSG_ADDR + 16'(word_cnt);
                    mem_write_data = hdr_data;
                    if (last_word) begin
                        state_next = KICK;
                    end
                end
            end
            KICK: begin
                hash_start       = 1'b1;
                mem_grant_hasher = 1'b1;
                state_next       = WAIT_LO;
            end
            WAIT_LO: begin
                // A high done here is the idle level, not a completion.
                mem_grant_hasher = 1'b1;
                if (!hash_done) begin
                    state_next = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (hash_done) begin
                    scan_clear = 1'b1;
                    state_next = FETCH;
                end else begin
                    mem_grant_hasher = 1'b1;
                end
            end
            FETCH: begin
                if (fetch_cnt < FCNT_W'(NUM_NONCES)) begin
                    mem_addr = OUT_ADDR + 16'(fetch_cnt);
                end
                if (fetch_last) begin
                    state_next = REPORT;
                end
            end
            REPORT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_next = LOAD;
                end
            end
            default: begin
                state_next = LOAD;
            end
        endcase
    end

    // Read i returns READ_LAT cycles after its address, so capture lags the issue count.
    assign scan_valid = (state == FETCH) && (fetch_cnt >= FCNT_W'(READ_LAT));
    assign scan_idx   = IDX_W'(fetch_cnt - FCNT_W'(READ_LAT));

    hash_result_scan #(
        .NUM_NONCES (NUM_NONCES)
    ) u_scan (
        .clk      (clk),
        .reset    (reset),
        .clear    (scan_clear),
        .in_valid (scan_valid),
        .in_idx   (scan_idx),
        .in_h0    (mem_read_data),
        .target   (target_q),
        .found    (res_found),
        .nonce    (res_nonce),
        .min_h0   (res_min_h0)
    );

endmodule
